// File: rtl/bsg_downstream_in.sv
// Receive end of the 2-channel byte-serial link: four beats -> one 64-bit word -> FIFO toward the core, one token back per word consumed.
// Optional BSG_DS_IN_OVERFLOW_CHECK_EN adds a sticky overflow_err output for writes dropped on a full FIFO.
module bsg_downstream_in #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_valid_in,
  input  logic [7:0]  io_data_in_ch0,
  input  logic [7:0]  io_data_in_ch1,
  output logic        io_token_out,
  output logic        core_valid_out,
  output logic [63:0] core_data_out,
`ifdef BSG_DS_IN_OVERFLOW_CHECK_EN
  output logic        overflow_err,
`endif
  input  logic        core_ready_in
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [1:0]    step;
  logic [31:0]   lo_q;
  logic [15:0]   hi_q;   // {hi[23:16], hi[7:0]} captured on step2
  logic [63:0]   word;
  logic [63:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [63:0]   head_nxt;
  logic          full, deq, wr, acc, drop;

  // step3 bytes go straight into the word, not through lo_q/hi_q
  assign word      = {io_data_in_ch1, hi_q[15:8], io_data_in_ch0, hi_q[7:0], lo_q};
  assign full      = (count == CW'(FIFO_DEPTH));
  assign deq       = core_valid_out & core_ready_in;
  assign wr        = io_valid_in & (step == 2'd3);
  assign acc       = wr & (~full | deq);
  assign drop      = wr & full & ~deq;
  assign count_nxt = count + CW'(acc) - CW'(deq);
  assign rd_nxt    = rd_ptr + PW'(deq);

  // Head register: new word bypasses storage when nothing older remains after this cycle's dequeue
  always_comb begin
    head_nxt = core_data_out;
    if (count_nxt != '0) begin
      if (count == CW'(deq)) head_nxt = word;
      else                   head_nxt = mem[rd_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step           <= 2'd0;
      lo_q           <= '0;
      hi_q           <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      core_valid_out <= 1'b0;
      core_data_out  <= '0;
      io_token_out   <= 1'b0;
    end else begin
      if (io_valid_in) begin
        step <= step + 2'd1;
        case (step)
          2'd0: begin lo_q[7:0]  <= io_data_in_ch0; lo_q[23:16] <= io_data_in_ch1; end
          2'd1: begin lo_q[15:8] <= io_data_in_ch0; lo_q[31:24] <= io_data_in_ch1; end
          2'd2: begin hi_q[7:0]  <= io_data_in_ch0; hi_q[15:8]  <= io_data_in_ch1; end
          default: ;
        endcase
      end
      if (acc) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr         <= rd_nxt;
      count          <= count_nxt;
      core_valid_out <= (count_nxt != '0);
      core_data_out  <= head_nxt;
      io_token_out   <= deq;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) mem[wr_ptr] <= word;
  end

`ifdef BSG_DS_IN_OVERFLOW_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      overflow_err <= 1'b0;
    else if (drop) overflow_err <= 1'b1;
  end
`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst && drop) $error("bsg_downstream_in: word dropped, FIFO full with no token outstanding");
  end
`endif
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_bsg_downstream_in.sv
// Bench for bsg_downstream_in: directed link scenarios plus random traffic against a queue-based reference model.
module tb_bsg_downstream_in;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        io_valid_in = 1'b0;
  logic [7:0]  io_data_in_ch0 = '0, io_data_in_ch1 = '0;
  logic        io_token_out, core_valid_out, core_ready_in = 1'b0;
  logic [63:0] core_data_out;
`ifdef BSG_DS_IN_OVERFLOW_CHECK_EN
  logic        overflow_err;
`endif

  bsg_downstream_in #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .io_valid_in(io_valid_in),
    .io_data_in_ch0(io_data_in_ch0), .io_data_in_ch1(io_data_in_ch1),
    .io_token_out(io_token_out), .core_valid_out(core_valid_out),
    .core_data_out(core_data_out),
`ifdef BSG_DS_IN_OVERFLOW_CHECK_EN
    .overflow_err(overflow_err),
`endif
    .core_ready_in(core_ready_in));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // reference model: beat index, captured bytes, word queue, expected token, drop flag
  int          m_step;
  logic [7:0]  bc0 [4], bc1 [4];
  logic [63:0] q [$];
  logic        m_tok;
  logic        m_ovf;

  task automatic model_clear();
    m_step = 0; q.delete(); m_tok = 1'b0; m_ovf = 1'b0;
  endtask

  // one clock edge; model consumes the inputs that were stable across it
  task automatic tick();
    logic deq;
    logic [63:0] w;
    @(posedge clk);
    if (rst) begin
      deq = (q.size() > 0) && core_ready_in;
      if (deq) void'(q.pop_front());
      m_tok = deq;
      if (io_valid_in) begin
        bc0[m_step] = io_data_in_ch0;
        bc1[m_step] = io_data_in_ch1;
        if (m_step == 3) begin
          w = {bc1[3], bc1[2], bc0[3], bc0[2], bc1[1], bc1[0], bc0[1], bc0[0]};
          if (q.size() < D) q.push_back(w);
          else m_ovf = 1'b1;
        end
        m_step = (m_step + 1) % 4;
      end
    end
    #1;
  endtask

  task automatic drive_beat(input logic [63:0] w, input int k);
    io_valid_in    = 1'b1;
    io_data_in_ch0 = w[(k/2)*32 + (k%2)*8 +: 8];
    io_data_in_ch1 = w[(k/2)*32 + 16 + (k%2)*8 +: 8];
  endtask

  task automatic send_word(input logic [63:0] w, input int gap);
    for (int k = 0; k < 4; k++) begin
      drive_beat(w, k);
      tick();
      io_valid_in = 1'b0;
      if (k < 3) for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b0; model_clear(); #1;
    total++; if (core_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", core_valid_out); end
    total++; if (core_data_out !== 64'h0) begin bad++; $display("FAIL reset_data got=%h want=0", core_data_out); end
    total++; if (io_token_out !== 1'b0) begin bad++; $display("FAIL reset_token got=%b want=0", io_token_out); end
`ifdef BSG_DS_IN_OVERFLOW_CHECK_EN
    total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow_err); end
`endif
    tick(); tick();
    @(negedge clk); rst = 1'b1;
    tick();
  endtask

  task automatic test_single(input int gap, input string nm);
    logic [63:0] w = 64'h0123456789ABCDEF;
    core_ready_in = 1'b1;
    send_word(w, gap);
    total++; if (core_valid_out !== 1'b1) begin bad++; $display("FAIL %s_valid got=%b want=1", nm, core_valid_out); end
    total++; if (core_data_out !== w) begin bad++; $display("FAIL %s_data got=%h want=%h", nm, core_data_out, w); end
    total++; if (io_token_out !== 1'b0) begin bad++; $display("FAIL %s_early_tok got=%b want=0", nm, io_token_out); end
    tick();
    total++; if (io_token_out !== 1'b1) begin bad++; $display("FAIL %s_tok got=%b want=1", nm, io_token_out); end
    total++; if (core_valid_out !== 1'b0) begin bad++; $display("FAIL %s_empty got=%b want=0", nm, core_valid_out); end
    tick();
    total++; if (io_token_out !== 1'b0) begin bad++; $display("FAIL %s_one_tok got=%b want=0", nm, io_token_out); end
  endtask

  task automatic test_fill_drain();
    logic [63:0] ws [4];
    core_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ws[i] = {32'hA5A5_0000 | 32'(i), 32'(i + 1)};
      send_word(ws[i], 0);
      total++; if (io_token_out !== 1'b0) begin bad++; $display("FAIL fill_tok%0d got=%b want=0", i, io_token_out); end
    end
    total++; if (q.size() != 4) begin bad++; $display("FAIL fill_model_count got=%0d want=4", q.size()); end
    core_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (core_valid_out !== 1'b1 || core_data_out !== ws[i]) begin
        bad++; $display("FAIL drain_data%0d got=%b/%h want=1/%h", i, core_valid_out, core_data_out, ws[i]); end
      tick();
      total++; if (io_token_out !== 1'b1) begin bad++; $display("FAIL drain_tok%0d got=%b want=1", i, io_token_out); end
    end
    total++; if (core_valid_out !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b want=0", core_valid_out); end
    tick();
    total++; if (io_token_out !== 1'b0) begin bad++; $display("FAIL drain_tok_end got=%b want=0", io_token_out); end
  endtask

  // full FIFO: 5th word lands with a dequeue, then a 6th with no dequeue is dropped
  task automatic test_full();
    logic [63:0] ws [6];
    core_ready_in = 1'b0;
    for (int i = 0; i < 6; i++) ws[i] = {32'hC0DE_0000 | 32'(i), 32'h1000 + 32'(i)};
    for (int i = 0; i < 4; i++) send_word(ws[i], 0);
    for (int k = 0; k < 4; k++) begin
      drive_beat(ws[4], k);
      if (k == 3) core_ready_in = 1'b1;
      tick();
    end
    io_valid_in = 1'b0; core_ready_in = 1'b0;
    total++; if (io_token_out !== 1'b1) begin bad++; $display("FAIL full_deq_tok got=%b want=1", io_token_out); end
    total++; if (core_data_out !== ws[1]) begin bad++; $display("FAIL full_deq_head got=%h want=%h", core_data_out, ws[1]); end
    total++; if (q.size() != 4) begin bad++; $display("FAIL full_deq_model got=%0d want=4", q.size()); end
    send_word(ws[5], 0);
    tick();
`ifdef BSG_DS_IN_OVERFLOW_CHECK_EN
    total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", overflow_err); end
    tick(); tick();
    total++; if (overflow_err !== m_ovf) begin bad++; $display("FAIL ovf_sticky got=%b want=%b", overflow_err, m_ovf); end
`endif
    core_ready_in = 1'b1;
    for (int i = 1; i < 5; i++) begin
      total++; if (core_valid_out !== 1'b1 || core_data_out !== ws[i]) begin
        bad++; $display("FAIL drop_data%0d got=%b/%h want=1/%h", i, core_valid_out, core_data_out, ws[i]); end
      tick();
      total++; if (io_token_out !== 1'b1) begin bad++; $display("FAIL drop_tok%0d got=%b want=1", i, io_token_out); end
    end
    total++; if (core_valid_out !== 1'b0) begin bad++; $display("FAIL drop_empty got=%b want=0", core_valid_out); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [63:0] stale = 64'hDEAD_BEEF_DEAD_BEEF, fresh = 64'h1122_3344_5566_7788;
    core_ready_in = 1'b0;
    for (int k = 0; k < 2; k++) begin drive_beat(stale, k); tick(); end
    io_valid_in = 1'b0;
    @(negedge clk); rst = 1'b0; model_clear(); #1;
    total++; if (core_valid_out !== 1'b0 || io_token_out !== 1'b0) begin
      bad++; $display("FAIL midrst_out got=%b/%b want=0/0", core_valid_out, io_token_out); end
`ifdef BSG_DS_IN_OVERFLOW_CHECK_EN
    total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL midrst_ovf got=%b want=0", overflow_err); end
`endif
    tick();
    @(negedge clk); rst = 1'b1;
    tick();
    send_word(fresh, 1);
    total++; if (core_valid_out !== 1'b1 || core_data_out !== fresh) begin
      bad++; $display("FAIL midrst_data got=%b/%h want=1/%h", core_valid_out, core_data_out, fresh); end
    core_ready_in = 1'b1;
    tick();
    total++; if (io_token_out !== 1'b1 || core_valid_out !== 1'b0) begin
      bad++; $display("FAIL midrst_tok got=%b/%b want=1/0", io_token_out, core_valid_out); end
    tick();
  endtask

  task automatic test_random();
    int words_in = 0, toks = 0;
    for (int c = 0; c < 600; c++) begin
      core_ready_in  = ($urandom_range(0, 9) < ((c / 100) % 2 ? 8 : 3));
      io_valid_in    = ($urandom_range(0, 9) < 7);
      io_data_in_ch0 = 8'($urandom);
      io_data_in_ch1 = 8'($urandom);
      // transmitter respects credits: never complete a word into a full FIFO without a dequeue
      if (io_valid_in && m_step == 3 && q.size() == D && !core_ready_in) io_valid_in = 1'b0;
      if (io_valid_in && m_step == 3) words_in++;
      tick();
      if (io_token_out === 1'b1) toks++;
      total++; if (core_valid_out !== (q.size() > 0)) begin
        bad++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, core_valid_out, q.size() > 0); end
      if (q.size() > 0) begin
        total++; if (core_data_out !== q[0]) begin
          bad++; $display("FAIL rnd_data c=%0d got=%h want=%h", c, core_data_out, q[0]); end
      end
      total++; if (io_token_out !== m_tok) begin
        bad++; $display("FAIL rnd_tok c=%0d got=%b want=%b", c, io_token_out, m_tok); end
    end
    io_valid_in = 1'b0;
    total++; if (toks > words_in) begin bad++; $display("FAIL rnd_credit got=%0d want<=%0d", toks, words_in); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single(0, "single");
    test_single(3, "gaps");
    test_fill_drain();
    test_full();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
